// File: rtl/present_sbox_pkg.sv
// Shared types and constants for the dual-rail PRESENT S-box engine.
// Optional rail-consistency checking is enabled by defining SBOX_DR_FAULT_CHECK_EN.
package present_sbox_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      EVAL,
      CHK,
      DONE
   } sbox_dr_state_t;

   typedef struct packed {
      logic [3:0] u;
      logic [3:0] c;
   } dr_nibble_t;

   // Ascending range, so the leftmost entry is S(0).
   localparam logic [0:15][3:0] SBOX_LUT = {
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam dr_nibble_t SPACER = '0;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_LUT[x];
   endfunction

endpackage

// File: rtl/present_sbox_dr_lane.sv
// One 4-bit dual-rail S-box lane: loads S(x)/~S(x) on eval, holds on hold, else spacer.
// With SBOX_DR_FAULT_CHECK_EN defined, flt_inj_i collapses the complement rail onto the true rail.
module present_sbox_dr_lane
   import present_sbox_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] nibble_i,
   input  logic       eval_i,
   input  logic       hold_i,
   input  logic       flt_inj_i,
   output logic [3:0] u_o,
   output logic [3:0] c_o,
   output logic       legal_o
);

   dr_nibble_t pair_d, pair_q;
   logic [3:0] s_val;

   assign s_val = sbox(nibble_i);

   always_comb begin
      // NOTE: default first so every path assigns pair_d and no latch is inferred.
      pair_d = SPACER;
      if (eval_i) begin
         pair_d.u = s_val;
`ifdef SBOX_DR_FAULT_CHECK_EN
         pair_d.c = flt_inj_i ? s_val : ~s_val;
`else
         pair_d.c = ~s_val;
`endif
      end else if (hold_i) begin
         pair_d = pair_q;
      end
   end

`ifndef SBOX_DR_FAULT_CHECK_EN
   logic unused_flt_inj;
   assign unused_flt_inj = flt_inj_i;
`endif

   // NOTE: non-blocking assignments in clocked processes avoid simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pair_q <= SPACER;
      else        pair_q <= pair_d;
   end

   assign u_o     = pair_q.u;
   assign c_o     = pair_q.c;
   assign legal_o = ((pair_q.u ^ pair_q.c) == 4'hF);

endmodule

// File: rtl/present_sbox_dr_engine.sv
// Multi-lane dual-rail PRESENT S-box layer with precharge/evaluate/check phase control.
// Per-lane rail fault detection is enabled by defining SBOX_DR_FAULT_CHECK_EN.
module present_sbox_dr_engine
   import present_sbox_pkg::*;
#(
   parameter int LANES      = 16,
   parameter int PRE_CYCLES = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*LANES-1:0]   in_data,
   input  logic [LANES-1:0]     flt_inj,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*LANES-1:0]   out_u,
   output logic [4*LANES-1:0]   out_c,
   output logic [LANES-1:0]     fault
);

   localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);

   sbox_dr_state_t     state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [4*LANES-1:0] opnd_q, opnd_d;
   logic [LANES-1:0]   legal;
   logic               accept, eval_en, hold_en;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign eval_en   = (state_q == EVAL);
   // Results survive CHK and a stalled DONE; any other cycle drives spacer.
   assign hold_en   = (state_q == CHK) || ((state_q == DONE) && !out_ready);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         PRE:     if (cnt_q == 4'd0) state_d = EVAL;
                  else               cnt_d   = cnt_q - 4'd1;
         EVAL:    state_d = CHK;
         CHK:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         opnd_d  = in_data;
         cnt_d   = PRE_LOAD;
         state_d = PRE;
      end
   end

   // NOTE: the operand register is reset too, so an aborted operation leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      present_sbox_dr_lane u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .nibble_i  (opnd_q[4*i +: 4]),
         .eval_i    (eval_en),
         .hold_i    (hold_en),
         .flt_inj_i (flt_inj[i]),
         .u_o       (out_u[4*i +: 4]),
         .c_o       (out_c[4*i +: 4]),
         .legal_o   (legal[i])
      );
   end

`ifdef SBOX_DR_FAULT_CHECK_EN
   logic [LANES-1:0] fault_q, fault_d;

   always_comb begin
      fault_d = fault_q;
      if (accept)                fault_d = '0;
      else if (state_q == CHK)   fault_d = fault_q | ~legal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_q <= '0;
      else        fault_q <= fault_d;
   end

   assign fault = fault_q;
`else
   logic unused_legal;
   assign unused_legal = ^legal;
   assign fault        = '0;
`endif

endmodule

// File: tb/tb_present_sbox_dr_engine.sv
// Scoreboard bench for present_sbox_dr_engine: two instances (PRE_CYCLES=1 and 4),
// directed vectors with hand-computed S-box results, monitors pop expectations on handshake.
module tb_present_sbox_dr_engine;

   localparam int LANES = 16;
   localparam int W     = 4 * LANES;

   typedef struct packed {
      logic [W-1:0]     u;
      logic [W-1:0]     c;
      logic [LANES-1:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [W-1:0]     a_in_data, a_out_u, a_out_c;
   logic [LANES-1:0] a_flt_inj, a_fault;

   logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [W-1:0]     b_in_data, b_out_u, b_out_c;
   logic [LANES-1:0] b_flt_inj, b_fault;

   present_sbox_dr_engine #(.LANES(LANES), .PRE_CYCLES(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .flt_inj(a_flt_inj), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_u(a_out_u), .out_c(a_out_c), .fault(a_fault)
   );

   present_sbox_dr_engine #(.LANES(LANES), .PRE_CYCLES(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .flt_inj(b_flt_inj), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_u(b_out_u), .out_c(b_out_c), .fault(b_fault)
   );

   int   checks = 0;
   int   failures = 0;
   exp_t a_q[$];
   exp_t b_q[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] u, input logic [W-1:0] c,
                               input logic [LANES-1:0] f);
      exp_t e;
      e.u = u;
      e.c = c;
      e.f = f;
      return e;
   endfunction

   // Monitors: pop one expectation per completed output handshake.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && a_out_valid && a_out_ready) begin
         if (a_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_output: got u=%h required no output", a_out_u);
         end else begin
            e = a_q.pop_front();
            check("a_out_u", a_out_u, e.u);
            check("a_out_c", a_out_c, e.c);
            check("a_fault", W'(a_fault), W'(e.f));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && b_out_valid && b_out_ready) begin
         if (b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_output: got u=%h required no output", b_out_u);
         end else begin
            e = b_q.pop_front();
            check("b_out_u", b_out_u, e.u);
            check("b_out_c", b_out_c, e.c);
            check("b_fault", W'(b_fault), W'(e.f));
         end
      end
   end

   task automatic a_drive(input logic [W-1:0] data, input logic [LANES-1:0] flt);
      a_in_valid = 1'b1;
      a_in_data  = data;
      a_flt_inj  = flt;
   endtask

   task automatic a_accept(input exp_t e, input bit push, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!a_in_ready && waited < 20);
      if (!a_in_ready) begin
         checks++;
         failures++;
         $display("FAIL a_accept_timeout: in_ready=%b required 1", a_in_ready);
      end
      @(posedge clk);
      if (push) a_q.push_back(e);
      #1;
      a_in_valid = 1'b0;
      a_in_data  = ~a_in_data;
   endtask

   // Counts rising edges after the accept edge until out_valid is seen.
   task automatic a_wait_valid(input string name, input int req_edges);
      int edges;
      bit seen;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         seen = a_out_valid;
      end
      check(name, W'(edges), W'(req_edges));
   endtask

   logic [W-1:0] vec_in  [3];
   logic [W-1:0] vec_exp [3];
   logic [W-1:0] flt_c;
   logic [LANES-1:0] flt_f;
   localparam logic [W-1:0] OP1_IN  = 64'h0123456789ABCDEF;
   localparam logic [W-1:0] OP1_EXP = 64'hC56B90AD3EF84712;

   initial begin
      int w;
      int edges;
      bit seen;

      vec_in[0]  = 64'hFEDCBA9876543210;  vec_exp[0] = 64'h21748FE3DA09B65C;
      vec_in[1]  = 64'hFFFFFFFFFFFFFFFF;  vec_exp[1] = 64'h2222222222222222;
      vec_in[2]  = 64'hDEADBEEF00000000;  vec_exp[2] = 64'h71F78112CCCCCCCC;
`ifdef SBOX_DR_FAULT_CHECK_EN
      flt_c = 64'h3333333333333C33;
      flt_f = 16'h0004;
`else
      flt_c = 64'h3333333333333333;
      flt_f = 16'h0000;
`endif

      a_in_valid = 1'b0; a_in_data = '0; a_flt_inj = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_flt_inj = '0; b_out_ready = 1'b1;

      #12;
      check("rst_in_ready",  W'(a_in_ready),  W'(1));
      check("rst_out_valid", W'(a_out_valid), W'(0));
      check("rst_out_u",     a_out_u,         '0);
      check("rst_out_c",     a_out_c,         '0);
      check("rst_fault",     W'(a_fault),     '0);
      check("rst_b_in_ready", W'(b_in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single op, then a handful of further vectors.
      @(posedge clk); #1;
      a_drive(OP1_IN, '0);
      a_accept(mk(OP1_EXP, ~OP1_EXP, '0), 1'b1, w);
      a_wait_valid("a_lat_op1", 3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a_drive(vec_in[i], '0);
         a_accept(mk(vec_exp[i], ~vec_exp[i], '0), 1'b1, w);
         a_wait_valid("a_lat_vec", 3);
      end

      // Backpressure: output held stable while out_ready is low.
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      a_drive(OP1_IN, '0);
      a_accept(mk(OP1_EXP, ~OP1_EXP, '0), 1'b1, w);
      a_wait_valid("a_lat_bp", 3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("a_bp_valid",    W'(a_out_valid), W'(1));
         check("a_bp_u",        a_out_u,         OP1_EXP);
         check("a_bp_c",        a_out_c,         ~OP1_EXP);
         check("a_bp_in_ready", W'(a_in_ready),  W'(0));
      end

      // Back-to-back: release with a new operand waiting.
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      a_drive({LANES{4'hF}}, '0);
      a_accept(mk({LANES{4'h2}}, {LANES{4'hD}}, '0), 1'b1, w);
      check("a_b2b_immediate", W'(w), W'(1));
      @(negedge clk);
      check("a_b2b_spacer_valid", W'(a_out_valid), W'(0));
      check("a_b2b_spacer_u",     a_out_u,         '0);
      check("a_b2b_spacer_c",     a_out_c,         '0);
      a_wait_valid("a_lat_b2b", 3);

      // Fault injection on lane 2 with all-zero input.
      @(posedge clk); #1;
      a_drive('0, 16'h0004);
      a_accept(mk({LANES{4'hC}}, flt_c, flt_f), 1'b1, w);
      a_wait_valid("a_lat_flt", 3);

      // Reset during EVAL: outputs and in_ready respond without a clock edge.
      @(posedge clk); #1;
      a_drive(OP1_IN, '0);
      a_accept(mk(OP1_EXP, ~OP1_EXP, '0), 1'b0, w);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("a_rst_eval_valid",    W'(a_out_valid), W'(0));
      check("a_rst_eval_u",        a_out_u,         '0);
      check("a_rst_eval_c",        a_out_c,         '0);
      check("a_rst_eval_in_ready", W'(a_in_ready),  W'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while a result is stalled in DONE.
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      a_drive(vec_in[0], '0);
      a_accept(mk(vec_exp[0], ~vec_exp[0], '0), 1'b0, w);
      a_wait_valid("a_lat_rst_done", 3);
      #2 rst_n = 1'b0;
      #1;
      check("a_rst_done_valid",    W'(a_out_valid), W'(0));
      check("a_rst_done_u",        a_out_u,         '0);
      check("a_rst_done_c",        a_out_c,         '0);
      check("a_rst_done_in_ready", W'(a_in_ready),  W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      a_out_ready = 1'b1;

      @(posedge clk); #1;
      a_drive(OP1_IN, '0);
      a_accept(mk(OP1_EXP, ~OP1_EXP, '0), 1'b1, w);
      a_wait_valid("a_lat_after_rst", 3);

      // Precharge depth 4 on the second instance.
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      b_in_data  = {LANES{4'h5}};
      @(negedge clk);
      check("b_in_ready", W'(b_in_ready), W'(1));
      @(posedge clk);
      b_q.push_back(mk('0, {LANES{4'hF}}, '0));
      #1;
      b_in_valid = 1'b0;
      b_in_data  = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b_pre_valid", W'(b_out_valid), W'(0));
         check("b_pre_u",     b_out_u,         '0);
         check("b_pre_c",     b_out_c,         '0);
      end
      edges = 3;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         seen = b_out_valid;
      end
      check("b_lat", W'(edges), W'(6));

      repeat (5) @(negedge clk);
      check("a_queue_empty", W'(a_q.size()), '0);
      check("b_queue_empty", W'(b_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/present_sbox_dr_engine.md
# present_sbox_dr_engine

Parametrised, clocked dual-rail PRESENT S-box layer. It replaces the single-bit precharge/evaluate BDD cell with a multi-lane engine of LANES 4-bit nibbles and a precharge → evaluate → completion-check phase controller. It has valid/ready handshakes on both sides and optional rail-consistency fault detection. It sits between the round-key XOR and the pLayer in the PRESENT datapath.

## Interface
Parameters:
- LANES, default 16: number of 4-bit S-box lanes (16 covers the full 64-bit state). Legal range 1..32.
- PRE_CYCLES, default 1: precharge (spacer) cycles per operation. Legal range 1..15.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input nibble vector valid.
- in_ready, output, 1: engine can accept.
- in_data, input, 4*LANES: input nibbles; lane i is bits [4i+3:4i].
- flt_inj, input, LANES: test-only. Bit i forces lane i's complement rail equal to its true rail during evaluate.
- out_valid, output, 1: dual-rail result valid.
- out_ready, input, 1: consumer accepts.
- out_u, output, 4*LANES: uncomplemented rail.
- out_c, output, 4*LANES: complemented rail.
- fault, output, LANES: per-lane rail-consistency fault, sticky per operation.

## Operation
- States: IDLE, PRE, EVAL, CHK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data into the operand register, load the precharge counter with PRE_CYCLES-1, go to PRE.
- PRE:
  - out_u=out_c=0 (spacer).
  - Counter decrements each cycle. At 0, go to EVAL.
- EVAL:
  - Each lane computes S(x) using the PRESENT table 0..F → C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - Register out_u=S(x) and out_c=~S(x).
  - If flt_inj[i]=1, lane i registers out_c=S(x) instead.
  - Go to CHK.
- CHK:
  - A nibble pair is legal only if out_u ^ out_c == 4'hF.
  - fault[i] is set if lane i is illegal (see Configuration).
  - Go to DONE.
- DONE:
  - out_valid=1.
  - out_u, out_c and fault are held stable until out_ready.
  - in_ready=out_ready, so back-to-back operation is allowed.
  - On out_ready with in_valid: capture the new operand and go straight to PRE.
  - On out_ready without in_valid: go to IDLE.
- Outside DONE: out_valid=0, and out_u/out_c hold spacer (all zeros) except during CHK.
- fault clears on entry to PRE.
- in_data is not sampled outside an accept cycle.
- in_data changing after acceptance has no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_u=0, out_c=0, fault=0, operand register=0.
- Reset asserted mid-operation returns to IDLE asynchronously. Outputs go to spacer immediately, and the in-flight operand is discarded.
- Latency: an accept at edge T gives out_valid high after edge T+PRE_CYCLES+2.
- Minimum issue interval: PRE_CYCLES+3 cycles with out_ready held high.
- Precharge is never skipped: every operation passes through at least one spacer cycle, including back-to-back operations.
- out_valid is held while out_ready=0 for any number of cycles. No data changes while held.

## Configuration
- Macro SBOX_DR_FAULT_CHECK_EN.
- Defined:
  - The CHK comparison drives fault.
  - flt_inj is honoured in EVAL.
- Undefined:
  - fault is tied to 0 and flt_inj is ignored; out_c is always ~out_u.
  - The CHK state is still traversed, so latency is unchanged.

## Structure
- Package present_sbox_pkg holds:
  - the S-box lookup constant SBOX_LUT (16×4);
  - the state enum sbox_dr_state_t;
  - typedef dr_nibble_t (u, c 4-bit pair);
  - constant SPACER = 0.
- Sub-module present_sbox_dr_lane, instantiated LANES times via generate:
  - inputs: one nibble, eval strobe, flt_inj bit;
  - outputs: registered dual-rail pair and a legality flag.
- The top holds the FSM, precharge counter and handshakes.

## Test plan
- Reset then single op: LANES=16, PRE_CYCLES=1, in_data=64'h0123456789ABCDEF accepted at T → out_valid at T+3 with out_u=64'hC56B90AD3EF84712 and out_c=~out_u; fault=0.
- Precharge depth: PRE_CYCLES=4, in_data all 4'h5 → out_u/out_c=0 for 4 cycles, then out_valid at T+6 with out_u all 4'h0 and out_c all 4'hF.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles → outputs stable, in_ready=0.
  - Then raise out_ready with in_valid (in_data all 4'hF) → immediate accept, then one spacer cycle, then out_u all 4'h2.
- Fault check (macro defined): flt_inj=16'h0004, in_data all 4'h0 → fault=16'h0004 and out_c lane 2 = 4'hC.
- Same fault stimulus with macro undefined → fault=0 and out_c lane 2 = 4'h3.
- Reset mid-EVAL: assert rst_n=0 during EVAL → out_u=out_c=0, out_valid=0, in_ready=1 without waiting for a clock edge. A subsequent op completes correctly.
